// File: rtl/vedic_mul8_seq_pkg.sv
// Shared types and constants for the iterative Vedic multiplier controller.
// The shift table is expressed in terms of the half width so it follows W.
package vedic_mul8_seq_pkg;

    localparam int W_DEF  = 8;
    localparam int NSTEP  = 4;
    localparam int STEP_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [STEP_W-1:0] step_t;

    localparam step_t LAST_STEP = step_t'(NSTEP - 1);

    // Partial-product weight per step: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic int unsigned step_shift(input step_t step, input int unsigned h);
        int unsigned sh;
        case (step)
            2'd0:    sh = 0;
            2'd1:    sh = h;
            2'd2:    sh = h;
            default: sh = 2 * h;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/vedic_mul8_seq_vedic4x4.sv
// Combinational 4x4 Vedic (Urdhva Tiryagbhyam) multiplier built from
// full-adder cells and 4-bit ripple-carry adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[4];
endmodule

module vedic2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;

    assign p[0] = a[0] & b[0];

    full_adder u_ha0 (
        .a    (a[1] & b[0]),
        .b    (a[0] & b[1]),
        .cin  (1'b0),
        .s    (p[1]),
        .cout (c1)
    );

    full_adder u_ha1 (
        .a    (a[1] & b[1]),
        .b    (c1),
        .cin  (1'b0),
        .s    (p[2]),
        .cout (p[3])
    );
endmodule

module vedic4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    logic [3:0] mid_s, lo_s;
    logic       mid_c, lo_c;
    logic       unused_cout;

    vedic2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

    rca4 u_mid (.a(q1),    .b(q2),                .cin(1'b0), .s(mid_s), .cout(mid_c));
    rca4 u_lo  (.a(mid_s), .b({2'b00, q0[3:2]}), .cin(1'b0), .s(lo_s),  .cout(lo_c));

    // The cross-term sum never exceeds 5 bits, so at most one of the two carries is set.
    rca4 u_hi (
        .a    (q3),
        .b    ({1'b0, mid_c | lo_c, lo_s[3:2]}),
        .cin  (1'b0),
        .s    (p[7:4]),
        .cout (unused_cout)
    );

    assign p[3:0] = {lo_s[1:0], q0[1:0]};
endmodule

// File: rtl/vedic_mul8_seq.sv
// Iterative WxW unsigned multiplier: one HxH partial-product unit and one
// 2W-bit accumulator time-shared over four steps, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// MUL   | accumulating partial product for step_q (0..3)
// DONE  | out_valid=1, p held until out_ready
module vedic_mul8_seq
    import vedic_mul8_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);
    localparam int H = W / 2;

    state_t         state_q, state_d;
    step_t          step_q, step_d;
    logic [W-1:0]   ra_q, ra_d;
    logic [W-1:0]   rb_q, rb_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] p_q, p_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [H-1:0]   sel_a, sel_b;
    logic [2*H-1:0] pp;
    logic [2*W-1:0] pp_sh;
    logic [2*W-1:0] acc_sum;

    assign sel_a = step_q[0] ? ra_q[W-1:H] : ra_q[H-1:0];
    assign sel_b = step_q[1] ? rb_q[W-1:H] : rb_q[H-1:0];

    if (H == 4) begin : g_vedic
        vedic4x4 u_pp (.a(sel_a), .b(sel_b), .p(pp));
    end else begin : g_generic
        assign pp = {{H{1'b0}}, sel_a} * {{H{1'b0}}, sel_b};
    end

    assign pp_sh   = {{(2*W-2*H){1'b0}}, pp} << step_shift(step_q, H);
    assign acc_sum = acc_q + pp_sh;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        acc_d       = acc_q;
        p_d         = p_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    ra_d       = a;
                    rb_d       = b;
                    acc_d      = '0;
                    step_d     = '0;
                    state_d    = MUL;
                    in_ready_d = 1'b0;
                end
            end
            MUL: begin
                in_ready_d = 1'b0;
                acc_d      = acc_sum;
                step_d     = step_q + step_t'(1);
                if (step_q == LAST_STEP) begin
                    p_d         = acc_sum;
                    out_valid_d = 1'b1;
                    step_d      = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                step_d      = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Self-checking bench: a transaction-level model (pending product plus
// edge count since accept) predicts in_ready, out_valid and p every cycle.
module tb_vedic_mul8_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;

    vedic_mul8_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    bit          m_pending;
    int          m_cnt;
    logic [15:0] m_prod;
    logic [15:0] m_p;
    int          m_accepts;
    int          m_handshakes;
    int          obs_handshakes;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model on the edge, check 1 time unit later.
    task automatic cycle(input logic r, input logic iv, input logic [7:0] av,
                         input logic [7:0] bv, input logic ordy);
        rst       = r;
        in_valid  = iv;
        a         = av;
        b         = bv;
        out_ready = ordy;
        if (!r && out_valid && ordy) obs_handshakes++;
        @(posedge clk);
        if (r) begin
            m_pending = 1'b0;
            m_cnt     = 0;
            m_p       = 16'h0000;
        end else if (!m_pending) begin
            if (iv) begin
                m_pending = 1'b1;
                m_cnt     = 0;
                m_prod    = 16'(av) * 16'(bv);
                m_accepts++;
            end
        end else if (m_cnt == 4) begin
            if (ordy) begin
                m_pending = 1'b0;
                m_handshakes++;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 4) m_p = m_prod;
        end
        #1;
        chk("in_ready",  {15'd0, in_ready},  {15'd0, !m_pending});
        chk("out_valid", {15'd0, out_valid}, {15'd0, (m_pending && m_cnt == 4)});
        chk("p", p, m_p);
    endtask

    // Accept one operation, optionally change the operand bus mid-flight and
    // hold out_ready low for 'hold' cycles once the result is up.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                          input logic [7:0] a2, input logic [7:0] b2);
        int left;
        int guard;
        left  = hold;
        guard = 0;
        cycle(1'b0, 1'b1, av, bv, 1'b1);
        while (m_pending && guard < 20) begin
            if (m_cnt == 4 && left > 0) begin
                cycle(1'b0, 1'b0, a2, b2, 1'b0);
                left--;
            end else begin
                cycle(1'b0, 1'b0, a2, b2, 1'b1);
            end
            guard++;
        end
        chk("op_done_bound", {15'd0, m_pending}, 16'd0);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        m_pending      = 1'b0;
        m_cnt          = 0;
        m_prod         = 16'h0000;
        m_p            = 16'h0000;
        m_accepts      = 0;
        m_handshakes   = 0;
        obs_handshakes = 0;
        rst            = 1'b1;
        in_valid       = 1'b0;
        a              = 8'h00;
        b              = 8'h00;
        out_ready      = 1'b0;

        cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h55, 8'h66, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        run_op(8'h12, 8'h34, 0, 8'h12, 8'h34);
        chk("p_12x34", p, 16'h03A8);
        run_op(8'hFF, 8'hFF, 0, 8'hFF, 8'hFF);
        chk("p_FFxFF", p, 16'hFE01);
        run_op(8'h00, 8'hA5, 0, 8'h00, 8'hA5);
        run_op(8'h80, 8'h02, 0, 8'h80, 8'h02);
        chk("p_80x02", p, 16'h0100);
        run_op(8'h37, 8'hB9, 3, 8'h37, 8'hB9);
        run_op(8'h0F, 8'h0F, 0, 8'hFF, 8'hFF);
        chk("p_ignore_change", p, 16'h00E1);

        cycle(1'b0, 1'b1, 8'hC3, 8'h5A, 1'b1);
        cycle(1'b0, 1'b0, 8'hC3, 8'h5A, 1'b1);
        cycle(1'b0, 1'b0, 8'hC3, 8'h5A, 1'b1);
        cycle(1'b1, 1'b0, 8'hC3, 8'h5A, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        run_op(8'h03, 8'h07, 0, 8'h03, 8'h07);
        chk("p_03x07", p, 16'h0015);

        for (int i = 0; i < 200; i++)
            cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);

        for (int i = 0; i < 6000; i++)
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 6));

        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        chk("handshakes", 16'(obs_handshakes), 16'(m_handshakes));
        chk("model_activity", {15'd0, (m_accepts > 100)}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
